icw_ocw_control: RTL and testbench

- Upstream command front-end of the PIC: the CPU-side read/write control and initialization/operation command word decoder.
- Synchronizes the CPU bus strobes and runs the ICW1→ICW2→(ICW3)→(ICW4) initialization sequence.
- Decodes OCW1/OCW2/OCW3 writes.
- Drives the mode flags, vector base, mask register and read-status strobes consumed by the interrupt priority/ISR logic downstream.

---
 rtl/icw_ocw_control.sv | 218 +++++++++++++++++++++
 tb/tb_icw_ocw_control.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/icw_ocw_control.sv
// CPU-side command front-end: synchronizes WR_n/RD_n, runs the ICW1..ICW4
// initialization sequence and decodes OCW1/OCW2/OCW3 for the priority logic.
//
// state     | meaning
// IDLE      | after reset, waiting for ICW1
// WAIT_ICW2 | ICW1 seen, next A0=1 write is ICW2 (vector base)
// WAIT_ICW3 | cascade mode, next A0=1 write is ICW3
// WAIT_ICW4 | IC4 set, next A0=1 write is ICW4
// READY     | initialized, OCW writes accepted
module icw_ocw_control #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IMR_RESET   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       CS_n,
  input  logic       WR_n,
  input  logic       RD_n,
  input  logic       A0,
  input  logic [7:0] dataIn,
  output logic       LTIM,
  output logic       SNGL,
  output logic       AEOI,
  output logic       SFNM,
  output logic       AR,
  output logic [4:0] TReg,
  output logic [7:0] IMR,
  output logic [7:0] cascadeCfg,
  output logic       initDone,
  output logic       readIRR,
  output logic       readISR,
  output logic       readIMR,
  output logic       eoiPulse,
  output logic       eoiSpecific,
  output logic [2:0] eoiLevel,
  output logic       rotatePulse,
  output logic       prioritySet,
  output logic       pollCmd
);

  typedef enum logic [2:0] {IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] wr_sync_q, rd_sync_q;
  logic                   wr_prev_q, rd_prev_q;
  logic                   cap_cs_n_q, cap_a0_q;
  logic [7:0]             cap_d_q;

  logic       ltim_q, ltim_d, sngl_q, sngl_d, ic4_q, ic4_d;
  logic       aeoi_q, aeoi_d, sfnm_q, sfnm_d, ar_q, ar_d;
  logic [4:0] treg_q, treg_d;
  logic [7:0] imr_q, imr_d, casc_q, casc_d;
  logic       rsel_isr_q, rsel_isr_d;
  logic       eoi_q, eoi_d, eoi_spec_q, eoi_spec_d, rot_q, rot_d;
  logic       prio_q, prio_d, poll_q, poll_d;
  logic [2:0] eoi_lvl_q, eoi_lvl_d;
  logic       rd_irr_q, rd_irr_d, rd_isr_q, rd_isr_d, rd_imr_q, rd_imr_d;
  logic       wr_commit, rd_fall;

  assign wr_commit = wr_sync_q[SYNC_STAGES-1] & ~wr_prev_q & ~cap_cs_n_q;
  assign rd_fall   = ~rd_sync_q[SYNC_STAGES-1] & rd_prev_q & ~CS_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_sync_q  <= '1;
      rd_sync_q  <= '1;
      wr_prev_q  <= 1'b1;
      rd_prev_q  <= 1'b1;
      cap_cs_n_q <= 1'b0;
      cap_a0_q   <= 1'b0;
      cap_d_q    <= 8'h00;
      ltim_q     <= 1'b0;
      sngl_q     <= 1'b0;
      ic4_q      <= 1'b0;
      aeoi_q     <= 1'b0;
      sfnm_q     <= 1'b0;
      ar_q       <= 1'b0;
      treg_q     <= 5'd0;
      imr_q      <= IMR_RESET;
      casc_q     <= 8'h00;
      rsel_isr_q <= 1'b0;
      eoi_q      <= 1'b0;
      eoi_spec_q <= 1'b0;
      eoi_lvl_q  <= 3'd0;
      rot_q      <= 1'b0;
      prio_q     <= 1'b0;
      poll_q     <= 1'b0;
      rd_irr_q   <= 1'b0;
      rd_isr_q   <= 1'b0;
      rd_imr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_sync_q  <= {wr_sync_q[SYNC_STAGES-2:0], WR_n};
      rd_sync_q  <= {rd_sync_q[SYNC_STAGES-2:0], RD_n};
      wr_prev_q  <= wr_sync_q[SYNC_STAGES-1];
      rd_prev_q  <= rd_sync_q[SYNC_STAGES-1];
      // Keep sampling the bus while the first stage still sees the strobe low.
      if (!wr_sync_q[0]) begin
        cap_cs_n_q <= CS_n;
        cap_a0_q   <= A0;
        cap_d_q    <= dataIn;
      end
      ltim_q     <= ltim_d;
      sngl_q     <= sngl_d;
      ic4_q      <= ic4_d;
      aeoi_q     <= aeoi_d;
      sfnm_q     <= sfnm_d;
      ar_q       <= ar_d;
      treg_q     <= treg_d;
      imr_q      <= imr_d;
      casc_q     <= casc_d;
      rsel_isr_q <= rsel_isr_d;
      eoi_q      <= eoi_d;
      eoi_spec_q <= eoi_spec_d;
      eoi_lvl_q  <= eoi_lvl_d;
      rot_q      <= rot_d;
      prio_q     <= prio_d;
      poll_q     <= poll_d;
      rd_irr_q   <= rd_irr_d;
      rd_isr_q   <= rd_isr_d;
      rd_imr_q   <= rd_imr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ltim_d     = ltim_q;
    sngl_d     = sngl_q;
    ic4_d      = ic4_q;
    aeoi_d     = aeoi_q;
    sfnm_d     = sfnm_q;
    ar_d       = ar_q;
    treg_d     = treg_q;
    imr_d      = imr_q;
    casc_d     = casc_q;
    rsel_isr_d = rsel_isr_q;
    eoi_spec_d = eoi_spec_q;
    eoi_lvl_d  = eoi_lvl_q;
    eoi_d      = 1'b0;
    rot_d      = 1'b0;
    prio_d     = 1'b0;
    poll_d     = 1'b0;
    // Read strobes use the select held before any same-cycle OCW3.
    rd_irr_d   = rd_fall & ~A0 & ~rsel_isr_q;
    rd_isr_d   = rd_fall & ~A0 & rsel_isr_q;
    rd_imr_d   = rd_fall & A0;

    if (wr_commit) begin
      if (!cap_a0_q && cap_d_q[4]) begin
        ic4_d      = cap_d_q[0];
        sngl_d     = cap_d_q[1];
        ltim_d     = cap_d_q[3];
        imr_d      = 8'h00;
        aeoi_d     = 1'b0;
        sfnm_d     = 1'b0;
        ar_d       = 1'b0;
        rsel_isr_d = 1'b0;
        state_d    = WAIT_ICW2;
      end else if (cap_a0_q) begin
        case (state_q)
          WAIT_ICW2: begin
            treg_d = cap_d_q[7:3];
            if (!sngl_q)    state_d = WAIT_ICW3;
            else if (ic4_q) state_d = WAIT_ICW4;
            else            state_d = READY;
          end
          WAIT_ICW3: begin
            casc_d  = cap_d_q;
            state_d = ic4_q ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: begin
            aeoi_d  = cap_d_q[1];
            sfnm_d  = cap_d_q[4];
            state_d = READY;
          end
          READY:   imr_d = cap_d_q;
          default: ;
        endcase
      end else if (state_q == READY && !cap_d_q[3]) begin
        eoi_lvl_d = cap_d_q[2:0];
        case (cap_d_q[7:5])
          3'b001: begin eoi_d = 1'b1; eoi_spec_d = 1'b0; end
          3'b011: begin eoi_d = 1'b1; eoi_spec_d = 1'b1; end
          3'b101: begin eoi_d = 1'b1; eoi_spec_d = 1'b0; rot_d = 1'b1; end
          3'b111: begin eoi_d = 1'b1; eoi_spec_d = 1'b1; rot_d = 1'b1; end
          3'b100: ar_d   = 1'b1;
          3'b000: ar_d   = 1'b0;
          3'b110: prio_d = 1'b1;
          default: ;
        endcase
      end else if (state_q == READY) begin
        if (cap_d_q[1]) rsel_isr_d = cap_d_q[0];
        poll_d = cap_d_q[2];
      end
    end
  end

  assign LTIM        = ltim_q;
  assign SNGL        = sngl_q;
  assign AEOI        = aeoi_q;
  assign SFNM        = sfnm_q;
  assign AR          = ar_q;
  assign TReg        = treg_q;
  assign IMR         = imr_q;
  assign cascadeCfg  = casc_q;
  assign initDone    = (state_q == READY);
  assign readIRR     = rd_irr_q;
  assign readISR     = rd_isr_q;
  assign readIMR     = rd_imr_q;
  assign eoiPulse    = eoi_q;
  assign eoiSpecific = eoi_spec_q;
  assign eoiLevel    = eoi_lvl_q;
  assign rotatePulse = rot_q;
  assign prioritySet = prio_q;
  assign pollCmd     = poll_q;

endmodule

// File: tb/tb_icw_ocw_control.sv
// Directed bench for icw_ocw_control: table of write vectors with expected
// register state, plus hand sequences for strobes, reads and mid-sequence reset.
module tb_icw_ocw_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       CS_n = 1'b1, WR_n = 1'b1, RD_n = 1'b1, A0 = 1'b0;
  logic [7:0] dataIn = 8'h00;
  logic       LTIM, SNGL, AEOI, SFNM, AR, initDone;
  logic [4:0] TReg;
  logic [7:0] IMR, cascadeCfg;
  logic       readIRR, readISR, readIMR, eoiPulse, eoiSpecific;
  logic       rotatePulse, prioritySet, pollCmd;
  logic [2:0] eoiLevel;

  int pass_cnt = 0;
  int total    = 0;
  logic init_e2;

  icw_ocw_control #(.SYNC_STAGES(2), .IMR_RESET(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .CS_n(CS_n), .WR_n(WR_n), .RD_n(RD_n), .A0(A0),
    .dataIn(dataIn), .LTIM(LTIM), .SNGL(SNGL), .AEOI(AEOI), .SFNM(SFNM), .AR(AR),
    .TReg(TReg), .IMR(IMR), .cascadeCfg(cascadeCfg), .initDone(initDone),
    .readIRR(readIRR), .readISR(readISR), .readIMR(readIMR), .eoiPulse(eoiPulse),
    .eoiSpecific(eoiSpecific), .eoiLevel(eoiLevel), .rotatePulse(rotatePulse),
    .prioritySet(prioritySet), .pollCmd(pollCmd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cs_n;
    logic       a0;
    logic [7:0] d;
    logic [7:0] imr;
    logic [4:0] treg;
    logic [7:0] casc;
    logic       init;
    logic       sngl;
    logic       ltim;
    logic       aeoi;
    logic       sfnm;
    logic       ar;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [6:0] strobes();
    return {eoiPulse, rotatePulse, prioritySet, pollCmd, readIRR, readISR, readIMR};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Returns #1 after the third clk edge following the WR_n rise (commit edge).
  task automatic do_write(input logic cs, input logic a0, input logic [7:0] d);
    @(negedge clk);
    CS_n = cs; A0 = a0; dataIn = d; WR_n = 1'b0;
    repeat (3) @(negedge clk);
    WR_n = 1'b1;
    @(posedge clk); @(posedge clk); #1 init_e2 = initDone;
    @(posedge clk); #1;
  endtask

  // Returns #1 after the edge where the read strobe should be high.
  task automatic do_read(input logic cs, input logic a0);
    @(negedge clk);
    CS_n = cs; A0 = a0; RD_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic end_read();
    @(negedge clk);
    RD_n = 1'b1;
    CS_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    //            cs a0 d      imr    treg   casc   in sg lt ae sf ar
    vecs[0]  = '{0, 0, 8'h13, 8'h00, 5'h00, 8'h00, 0, 1, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 8'h40, 8'h00, 5'h08, 8'h00, 0, 1, 0, 0, 0, 0};
    vecs[2]  = '{0, 1, 8'h03, 8'h00, 5'h08, 8'h00, 1, 1, 0, 1, 0, 0};
    vecs[3]  = '{0, 1, 8'hA5, 8'hA5, 5'h08, 8'h00, 1, 1, 0, 1, 0, 0};
    vecs[4]  = '{0, 0, 8'h80, 8'hA5, 5'h08, 8'h00, 1, 1, 0, 1, 0, 1};
    vecs[5]  = '{0, 0, 8'h00, 8'hA5, 5'h08, 8'h00, 1, 1, 0, 1, 0, 0};
    vecs[6]  = '{1, 1, 8'h3C, 8'hA5, 5'h08, 8'h00, 1, 1, 0, 1, 0, 0};
    vecs[7]  = '{0, 0, 8'h18, 8'h00, 5'h08, 8'h00, 0, 0, 1, 0, 0, 0};
    vecs[8]  = '{0, 1, 8'h08, 8'h00, 5'h01, 8'h00, 0, 0, 1, 0, 0, 0};
    vecs[9]  = '{0, 0, 8'h00, 8'h00, 5'h01, 8'h00, 0, 0, 1, 0, 0, 0};
    vecs[10] = '{0, 1, 8'h04, 8'h00, 5'h01, 8'h04, 1, 0, 1, 0, 0, 0};
    vecs[11] = '{0, 0, 8'h11, 8'h00, 5'h01, 8'h04, 0, 0, 0, 0, 0, 0};
    vecs[12] = '{0, 1, 8'h20, 8'h00, 5'h04, 8'h04, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{0, 0, 8'h13, 8'h00, 5'h04, 8'h04, 0, 1, 0, 0, 0, 0};
    vecs[14] = '{0, 1, 8'hF8, 8'h00, 5'h1F, 8'h04, 0, 1, 0, 0, 0, 0};
    vecs[15] = '{0, 1, 8'h12, 8'h00, 5'h1F, 8'h04, 1, 1, 0, 1, 1, 0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_imr", IMR, 8'hFF);
    chk("rst_treg", {3'b0, TReg}, 8'h00);
    chk("rst_init", {7'b0, initDone}, 8'h00);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("rst_strobes", {1'b0, strobes()}, 8'h00);
    end

    for (int i = 0; i < 16; i++) begin
      do_write(vecs[i].cs_n, vecs[i].a0, vecs[i].d);
      repeat (2) @(posedge clk); #1;
      chk($sformatf("v%0d_imr", i), IMR, vecs[i].imr);
      chk($sformatf("v%0d_treg", i), {3'b0, TReg}, {3'b0, vecs[i].treg});
      chk($sformatf("v%0d_casc", i), cascadeCfg, vecs[i].casc);
      chk($sformatf("v%0d_flags", i),
          {2'b0, initDone, SNGL, LTIM, AEOI, SFNM, AR},
          {2'b0, vecs[i].init, vecs[i].sngl, vecs[i].ltim, vecs[i].aeoi,
           vecs[i].sfnm, vecs[i].ar});
    end

    // initDone latency: low on the 2nd edge, high on the 3rd after WR_n rises
    do_write(0, 0, 8'h13);
    do_write(0, 1, 8'h40);
    do_write(0, 1, 8'h03);
    chk("init_e2_low", {7'b0, init_e2}, 8'h00);
    chk("init_e3_high", {7'b0, initDone}, 8'h01);
    chk("init_treg", {3'b0, TReg}, 8'h08);
    chk("init_aeoi", {7'b0, AEOI}, 8'h01);

    // OCW2 specific EOI level 3
    do_write(0, 0, 8'h63);
    chk("eoi63_strobes", {1'b0, strobes()}, 8'h40);
    chk("eoi63_spec_lvl", {4'b0, eoiSpecific, eoiLevel}, 8'h0B);
    @(posedge clk); #1;
    chk("eoi63_after", {1'b0, strobes()}, 8'h00);
    chk("eoi63_hold", {4'b0, eoiSpecific, eoiLevel}, 8'h0B);

    // Rotate on non-specific EOI
    do_write(0, 0, 8'hA7);
    chk("eoiA7_strobes", {1'b0, strobes()}, 8'h60);
    chk("eoiA7_spec_lvl", {4'b0, eoiSpecific, eoiLevel}, 8'h07);

    // Set priority
    do_write(0, 0, 8'hC2);
    chk("prioC2_strobes", {1'b0, strobes()}, 8'h10);
    chk("prioC2_lvl", {5'b0, eoiLevel}, 8'h02);
    @(posedge clk); #1;
    chk("prioC2_after", {1'b0, strobes()}, 8'h00);

    // OCW3 read select ISR, then reads
    do_write(0, 0, 8'h0B);
    do_read(0, 0);
    chk("rd_isr", {1'b0, strobes()}, 8'h02);
    @(posedge clk); #1;
    chk("rd_isr_after", {1'b0, strobes()}, 8'h00);
    end_read();
    do_read(0, 1);
    chk("rd_imr", {1'b0, strobes()}, 8'h01);
    end_read();

    do_write(0, 0, 8'h0A);
    do_read(0, 0);
    chk("rd_irr", {1'b0, strobes()}, 8'h04);
    end_read();

    // Poll leaves read select on IRR
    do_write(0, 0, 8'h0C);
    chk("poll", {1'b0, strobes()}, 8'h08);
    @(posedge clk); #1;
    chk("poll_after", {1'b0, strobes()}, 8'h00);
    do_read(0, 0);
    chk("rd_irr_post_poll", {1'b0, strobes()}, 8'h04);
    end_read();

    // Read with chip deselected
    do_read(1, 0);
    chk("rd_cs_high", {1'b0, strobes()}, 8'h00);
    @(posedge clk); #1;
    chk("rd_cs_high_after", {1'b0, strobes()}, 8'h00);
    end_read();

    // Reset while waiting for ICW3 discards the sequence
    do_write(0, 0, 8'h10);
    do_write(0, 1, 8'h08);
    chk("pre_rst_treg", {3'b0, TReg}, 8'h01);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("mid_rst_imr", IMR, 8'hFF);
    chk("mid_rst_treg", {3'b0, TReg}, 8'h00);
    chk("mid_rst_init", {7'b0, initDone}, 8'h00);
    do_write(0, 1, 8'hAA);
    repeat (2) @(posedge clk); #1;
    chk("idle_write_imr", IMR, 8'hFF);
    chk("idle_write_casc", cascadeCfg, 8'h00);
    chk("idle_write_treg", {3'b0, TReg}, 8'h00);
    chk("idle_write_init", {7'b0, initDone}, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
